// File: rtl/paralelo_serial_pkg.sv
// -----------------------------------------------------------------------------
// paralelo_serial_pkg
// Definitions shared by the serial link receiver (serial_paralelo) and its
// transmitter (paralelo_serial): default comma symbol, default number of
// aligned commas needed to lock, and the receiver alignment state encoding.
// -----------------------------------------------------------------------------
package paralelo_serial_pkg;

  // Idle/comma byte the transmitter sends when it has no valid payload.
  localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;

  // Consecutive byte-aligned commas required before data is delivered.
  localparam int         SYNC_COUNT_DEF = 4;

  // Receiver alignment states.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,  // hunting for a comma at any bit offset
    SYNC   = 2'd1,  // byte boundary guessed, confirming with more commas
    ACTIVE = 2'd2   // locked, delivering bytes
  } sp_state_e;

endpackage : paralelo_serial_pkg

// File: rtl/serial_paralelo_align.sv
// -----------------------------------------------------------------------------
// serial_paralelo_align
// Bit-level front end of the receiver: serial shift register, bit counter
// within the current byte, and comma detection on the candidate byte.
//
// Ports
//   i_clk        serial bit clock
//   i_rst_n      asynchronous active-low reset
//   i_data       serial data bit, MSB first
//   i_aligned    1 while a byte boundary is assumed (SYNC/ACTIVE); the bit
//                counter free-runs 0..7, otherwise it is held at 0
//   o_nxt        candidate byte: previous 7 bits plus the current bit
//   o_com_det    o_nxt equals COM_SYMBOL
//   o_byte_done  the current edge completes a byte (bit counter == 7)
// -----------------------------------------------------------------------------
module serial_paralelo_align
  import paralelo_serial_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_data,
  input  logic       i_aligned,
  output logic [7:0] o_nxt,
  output logic       o_com_det,
  output logic       o_byte_done
);

  // Only the low 7 bits of the shifted history are ever read, so the oldest
  // bit is simply not stored.
  logic [6:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [7:0] w_nxt;

  assign w_nxt = {r_sr, i_data};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_sr      <= w_nxt[6:0];
      // 3-bit counter wraps 7 -> 0 naturally at each byte boundary.
      r_bit_cnt <= i_aligned ? r_bit_cnt + 3'd1 : 3'd0;
    end
  end

  assign o_nxt       = w_nxt;
  assign o_com_det   = (w_nxt == COM_SYMBOL);
  assign o_byte_done = (r_bit_cnt == 3'd7);

endmodule : serial_paralelo_align

// File: rtl/serial_paralelo.sv
// -----------------------------------------------------------------------------
// serial_paralelo
// Serial-to-parallel receiver with comma-based byte alignment. Hunts for
// COM_SYMBOL at any bit offset, confirms SYNC_COUNT aligned commas, then
// delivers one byte every 8 bit clocks for as long as reset stays released.
//
// Ports
//   clk_32f       serial bit clock (rising edge)
//   reset_L       asynchronous active-low reset
//   data_in       serial data, MSB first
//   data_out      last received byte, held 8 cycles
//   valid_out     data_out is payload (not COM_SYMBOL), held 8 cycles
//   byte_stb      one-cycle pulse when data_out/valid_out update
//   active        receiver is locked and delivering data
//   sync_err_cnt  saturating count of SYNC->SEARCH fallbacks; exists only
//                 when the macro SP_SYNC_ERR_CNT_EN is defined
// -----------------------------------------------------------------------------
module serial_paralelo
  import paralelo_serial_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEF
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
`ifdef SP_SYNC_ERR_CNT_EN
  ,
  output logic [7:0] sync_err_cnt
`endif
);

  localparam logic [7:0] SYNC_CNT_B = 8'(SYNC_COUNT);

  sp_state_e  r_state;
  logic [7:0] r_com_cnt;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_byte_stb;
  logic       r_active;
`ifdef SP_SYNC_ERR_CNT_EN
  logic [7:0] r_sync_err_cnt;
`endif

  logic [7:0] w_nxt;
  logic       w_com_det;
  logic       w_byte_done;
  logic       w_aligned;

  assign w_aligned = (r_state != SEARCH);

  serial_paralelo_align #(
    .COM_SYMBOL (COM_SYMBOL)
  ) u_align (
    .i_clk       (clk_32f),
    .i_rst_n     (reset_L),
    .i_data      (data_in),
    .i_aligned   (w_aligned),
    .o_nxt       (w_nxt),
    .o_com_det   (w_com_det),
    .o_byte_done (w_byte_done)
  );

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= SEARCH;
      r_com_cnt   <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_byte_stb  <= 1'b0;
      r_active    <= 1'b0;
`ifdef SP_SYNC_ERR_CNT_EN
      r_sync_err_cnt <= '0;
`endif
    end else begin
      r_byte_stb <= 1'b0;
      case (r_state)
        SEARCH: begin
          // A comma at any offset fixes the byte boundary at this edge;
          // it also counts as the first of the SYNC_COUNT commas.
          if (w_com_det) begin
            r_com_cnt <= 8'd1;
            if (SYNC_CNT_B <= 8'd1) begin
              r_state  <= ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= SYNC;
            end
          end
        end
        SYNC: begin
          if (w_byte_done) begin
            if (w_com_det) begin
              r_com_cnt <= r_com_cnt + 8'd1;
              if (r_com_cnt + 8'd1 == SYNC_CNT_B) begin
                r_state  <= ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              // Wrong boundary guess: drop back and hunt again.
              r_state   <= SEARCH;
              r_com_cnt <= '0;
`ifdef SP_SYNC_ERR_CNT_EN
              if (r_sync_err_cnt != 8'hFF) r_sync_err_cnt <= r_sync_err_cnt + 8'd1;
`endif
            end
          end
        end
        ACTIVE: begin
          // Lock is kept until reset; commas in the stream are idle bytes.
          if (w_byte_done) begin
            r_data_out  <= w_nxt;
            r_valid_out <= !w_com_det;
            r_byte_stb  <= 1'b1;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign byte_stb  = r_byte_stb;
  assign active    = r_active;
`ifdef SP_SYNC_ERR_CNT_EN
  assign sync_err_cnt = r_sync_err_cnt;
`endif

endmodule : serial_paralelo

// File: doc/serial_paralelo.md
SERIAL_PARALELO -- requirements
Module: serial_paralelo

Interface
REQ-001 Parameter COM_SYMBOL, default 8'hBC: idle/comma byte sent by the transmitter when it has no valid data.
REQ-002 Parameter SYNC_COUNT, default 4: number of consecutive byte-aligned COM_SYMBOL bytes required to declare sync.
REQ-003 clk_32f  input  1  serial bit clock; all state updates occur on its rising edge.
REQ-004 reset_L  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  1  serial data, one bit per clk_32f cycle, MSB first.
REQ-006 data_out  output  8  last received byte, held stable for 8 clk_32f cycles.
REQ-007 valid_out  output  1  data_out holds a payload byte, i.e. not COM_SYMBOL; held for 8 cycles.
REQ-008 byte_stb  output  1  one-cycle pulse on each clk_32f edge where data_out/valid_out are updated.
REQ-009 active  output  1  block is byte-aligned and delivering data.
REQ-010 sync_err_cnt  output  8  present only with SP_SYNC_ERR_CNT_EN (see Configuration).

Function
REQ-011 Each edge shall shift: sr <= {sr[6:0], data_in}; nxt = {sr[6:0], data_in} is the candidate byte.
REQ-012 FSM shall have the states SEARCH, SYNC and ACTIVE; SEARCH is the reset state.
REQ-013 In SEARCH, nxt==COM_SYMBOL at any bit offset shall go to SYNC with bit_cnt=0 and com_cnt=1.
REQ-014 In SYNC/ACTIVE, bit_cnt shall count 0..7 and wrap; a byte completes on the edge where bit_cnt==7 and nxt is that byte.
REQ-015 In SYNC, a completed byte ==COM_SYMBOL shall increment com_cnt; when com_cnt reaches SYNC_COUNT, the same edge shall enter ACTIVE and assert active.
REQ-016 In SYNC, a completed byte !=COM_SYMBOL shall return to SEARCH, clear com_cnt, and leave active=0.
REQ-017 In SYNC/SEARCH, data_out, valid_out and byte_stb shall stay 0.
REQ-018 In ACTIVE, each completed byte shall register data_out<=nxt and valid_out<=(nxt!=COM_SYMBOL), and pulse byte_stb.
REQ-019 Latency: data_out shall reflect a byte on the same edge that samples its LSB, i.e. visible one edge after the last bit is presented.
REQ-020 ACTIVE shall persist until reset; a payload byte equal to COM_SYMBOL shall be reported as idle (valid_out=0).
REQ-021 The first ACTIVE byte_stb shall occur 8 cycles after the edge that entered ACTIVE.

Reset
REQ-022 reset_L low shall immediately force state=SEARCH, sr=0, bit_cnt=0, com_cnt=0, data_out=8'h00, valid_out=0, byte_stb=0, active=0, sync_err_cnt=0.
REQ-023 Reset asserted mid-byte or mid-sync shall discard the partial byte; after release, alignment restarts from SEARCH.

Configuration
REQ-024 Macro SP_SYNC_ERR_CNT_EN defined: sync_err_cnt shall increment on each SYNC->SEARCH transition and saturate at 8'hFF.
REQ-025 Macro absent: the sync_err_cnt port and its counter shall not exist; all other behaviour is identical.

Structure
REQ-026 Package paralelo_serial_pkg shall hold the COM_SYMBOL default (8'hBC), SYNC_COUNT default, and the FSM state enum, shared with the transmitter.
REQ-027 Sub-module serial_paralelo_align (shift register + bit_cnt + COM detect) shall be instantiated once; the FSM and output registers stay in the top module.

Verification
REQ-028 Reset, then 4 aligned 8'hBC bytes -> active=1 on the 32nd bit edge; valid_out=0.
REQ-029 3 junk bits, then 4x 8'hBC, then 8'hCC, 8'hAA -> alignment found despite offset; data_out=8'hCC then 8'hAA, with valid_out=1 and one byte_stb each, 8 cycles apart.
REQ-030 2x 8'hBC, then 8'h55, then 4x 8'hBC -> SYNC->SEARCH on 8'h55, active asserts only after the later 4 BCs; sync_err_cnt=1 with the macro.
REQ-031 ACTIVE, stream 8'hAA, 8'hBC, 8'hCC -> valid_out sequence 1,0,1; data_out follows the bytes.
REQ-032 reset_L pulsed low mid-byte in ACTIVE -> all outputs 0 asynchronously; re-sync needs 4 fresh BCs.
REQ-033 Loopback with paralelo_serial (valid_in pattern 0,1,1,1,1,0,1,1; data 8'hCC/8'hAA) -> received valid/data match the sent sequence after sync.
